// File: rtl/param_fifo_buffer.sv
// Parametrised single-clock FIFO with occupancy count, sticky error flags and flush.
// Define BUFFER_FWFT_EN for first-word-fall-through reads; default is registered reads.
module param_fifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AE_THRESH  = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       write_en,
    input  logic                       read_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       isEmpty,
    output logic                       nearEmpty,
    output logic                       nearFull,
    output logic                       isFull,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  is_empty_s;
    logic                  is_full_s;
    logic                  near_empty_s;
    logic                  near_full_s;
    logic                  do_read_s;
    logic                  do_write_s;

    // Occupancy flags decoded from the registered count
    always_comb begin
        is_empty_s   = (count_r == CNT_ZERO);
        is_full_s    = (count_r == CNT_FULL);
        near_empty_s = (count_r >= CNT_ONE) && (count_r <= CNT_AE);
        near_full_s  = (count_r >= CNT_AF) && (count_r <= CNT_TOP);
    end

    // Accept decisions; flush suppresses both so it wins over traffic
    always_comb begin
        if (flush) begin
            do_read_s  = 1'b0;
            do_write_s = 1'b0;
        end else begin
            do_read_s  = read_en & ~is_empty_s;
            do_write_s = write_en & (~is_full_s | read_en);
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy count and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (do_write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_read_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_write_s, do_read_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (write_en & is_full_s & ~read_en) begin
                overflow_r <= 1'b1;
            end
            if (read_en & is_empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

`ifdef BUFFER_FWFT_EN
    // Head word is presented directly; read_en only acknowledges it
    always_comb begin
        data_out   = mem_r[rd_ptr_r];
        data_valid = ~is_empty_s;
    end
`else
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  dvalid_r;

    // Registered read port: valid pulses for one cycle per accepted pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r   <= {DATA_WIDTH{1'b0}};
            dvalid_r <= 1'b0;
        end else if (flush) begin
            dvalid_r <= 1'b0;
        end else if (do_read_s) begin
            dout_r   <= mem_r[rd_ptr_r];
            dvalid_r <= 1'b1;
        end else begin
            dvalid_r <= 1'b0;
        end
    end

    assign data_out   = dout_r;
    assign data_valid = dvalid_r;
`endif

    assign count     = count_r;
    assign isEmpty   = is_empty_s;
    assign isFull    = is_full_s;
    assign nearEmpty = near_empty_s;
    assign nearFull  = near_full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_param_fifo_buffer.sv
// Directed bench for param_fifo_buffer in its default registered-read build.
module tb_param_fifo_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] data_in;
    logic       write_en;
    logic       read_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic [4:0] count;
    logic       isEmpty, nearEmpty, nearFull, isFull;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;

    param_fifo_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .data_in    (data_in),
        .write_en   (write_en),
        .read_en    (read_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .count      (count),
        .isEmpty    (isEmpty),
        .nearEmpty  (nearEmpty),
        .nearFull   (nearFull),
        .isFull     (isFull),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(isEmpty), 32'd1);
        check({tag, "_nearempty"}, 32'(nearEmpty), 32'd0);
        check({tag, "_nearfull"}, 32'(nearFull), 32'd0);
        check({tag, "_full"}, 32'(isFull), 32'd0);
        check({tag, "_dout"}, 32'(data_out), 32'd0);
        check({tag, "_dvalid"}, 32'(data_valid), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_udf"}, 32'(underflow), 32'd0);
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            write_en = 1'b1;
            data_in  = base + 8'(i);
            step();
        end
        write_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; data_in = 8'h00; write_en = 1'b0; read_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        #2 rst = 1'b1;

        // Fill 0x01..0x10, checking count and flags at every step
        for (int i = 1; i <= 16; i++) begin
            write_en = 1'b1;
            data_in  = 8'(i);
            step();
            check("fill_count", 32'(count), 32'(i));
            check("fill_nearempty", 32'(nearEmpty), 32'((i >= 1 && i <= 4) ? 1 : 0));
            check("fill_nearfull", 32'(nearFull), 32'((i >= 12 && i <= 15) ? 1 : 0));
            check("fill_full", 32'(isFull), 32'((i == 16) ? 1 : 0));
            check("fill_empty", 32'(isEmpty), 32'd0);
            check("fill_ovf", 32'(overflow), 32'd0);
        end

        // Write into full FIFO without a pop is dropped
        data_in = 8'hAA;
        step();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        write_en = 1'b0;
        read_en  = 1'b1;
        step();
        check("ovf_head", 32'(data_out), 32'h01);
        check("ovf_head_valid", 32'(data_valid), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        read_en = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(isEmpty), 32'd1);
        check("flush_ovf", 32'(overflow), 32'd0);
        check("flush_dvalid", 32'(data_valid), 32'd0);
        check("flush_dout_hold", 32'(data_out), 32'h01);

        // Simultaneous read and write on a full FIFO
        fill(16, 8'h01);
        check("refill_full", 32'(isFull), 32'd1);
        write_en = 1'b1; read_en = 1'b1; data_in = 8'h55;
        step();
        write_en = 1'b0;
        check("rw_full_dout", 32'(data_out), 32'h01);
        check("rw_full_count", 32'(count), 32'd16);
        check("rw_full_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain_dout", 32'(data_out), (i < 15) ? 32'(i + 2) : 32'h55);
            check("drain_count", 32'(count), 32'(15 - i));
        end
        read_en = 1'b0;
        step();
        check("drain_idle_dvalid", 32'(data_valid), 32'd0);
        check("drain_udf", 32'(underflow), 32'd0);

        // Simultaneous read and write on an empty FIFO
        write_en = 1'b1; read_en = 1'b1; data_in = 8'h3C;
        step();
        write_en = 1'b0;
        check("rw_empty_udf", 32'(underflow), 32'd1);
        check("rw_empty_count", 32'(count), 32'd1);
        check("rw_empty_dvalid", 32'(data_valid), 32'd0);
        step();
        read_en = 1'b0;
        check("rw_empty_dout", 32'(data_out), 32'h3C);
        check("rw_empty_dvalid2", 32'(data_valid), 32'd1);
        check("rw_empty_count2", 32'(count), 32'd0);
        check("udf_sticky", 32'(underflow), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_udf", 32'(underflow), 32'd0);

        // Streaming at constant occupancy 8 across pointer wraps
        fill(8, 8'h80);
        for (int k = 0; k < 20; k++) begin
            write_en = 1'b1; read_en = 1'b1; data_in = 8'hC0 + 8'(k);
            step();
            check("stream_dout", 32'(data_out), (k < 8) ? 32'(8'h80 + 8'(k)) : 32'(8'hC0 + 8'(k - 8)));
            check("stream_count", 32'(count), 32'd8);
        end
        write_en = 1'b0; read_en = 1'b0;

        // Asynchronous reset mid-stream at count 9
        fill(1, 8'hEE);
        check("pre_rst_count", 32'(count), 32'd9);
        read_en = 1'b1;
        #3 rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        #2 rst = 1'b1;
        read_en = 1'b0;
        step();
        check("post_rst_empty", 32'(isEmpty), 32'd1);
        check("post_rst_dvalid", 32'(data_valid), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
